// File: rtl/playseq_memoria_gravavel.sv
// Recordable 16x4 sequence memory for PlaySeq: captures one-hot button presses
// and replays them through a ROM-compatible synchronous read port.
module playseq_memoria_gravavel #(
  parameter int TIMEOUT      = 5000,
  parameter int TIMEOUT_BITS = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       finalizar,
  input  logic [3:0] botoes,
  input  logic [3:0] address,
  output logic [3:0] data_out,
  output logic [4:0] tamanho,
  output logic       ultimo,
  output logic       gravando,
  output logic       pronto,
  output logic       erro,
  output logic [2:0] db_estado
);

  typedef enum logic [2:0] {
    OCIOSO        = 3'd0,
    ESPERA_JOGADA = 3'd1,
    ESPERA_SOLTA  = 3'd2,
    GRAVA         = 3'd3,
    PRONTO        = 3'd4,
    ERRO          = 3'd5
  } estado_t;

  localparam logic [TIMEOUT_BITS-1:0] TIMER_MAX = TIMEOUT_BITS'(TIMEOUT - 1);

  estado_t                 estado, proximo;
  logic [TIMEOUT_BITS-1:0] timer, timer_next;
  logic [4:0]              tamanho_next;
  logic [3:0]              jogada_reg, jogada_next;
  logic [3:0]              botoes_prev;
  logic [3:0]              mem [16];
  logic                    press_edge;
  logic                    one_hot;
  logic                    write_en;

  // A press is only recognised on the 0 -> non-zero transition of the buttons
  assign press_edge = (botoes != 4'd0) && (botoes_prev == 4'd0);
  assign one_hot    = (botoes != 4'd0) && ((botoes & (botoes - 4'd1)) == 4'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado      <= OCIOSO;
      timer       <= '0;
      tamanho     <= 5'd0;
      jogada_reg  <= 4'd0;
      botoes_prev <= 4'd0;
    end else begin
      estado      <= proximo;
      timer       <= timer_next;
      tamanho     <= tamanho_next;
      jogada_reg  <= jogada_next;
      botoes_prev <= botoes;
    end
  end

  always_comb begin
    proximo      = estado;
    timer_next   = timer;
    tamanho_next = tamanho;
    jogada_next  = jogada_reg;
    write_en     = 1'b0;
    if (iniciar) begin
      proximo      = ESPERA_JOGADA;
      timer_next   = '0;
      tamanho_next = 5'd0;
      jogada_next  = 4'd0;
    end else begin
      case (estado)
        ESPERA_JOGADA: begin
          if (press_edge) begin
            jogada_next = botoes;
            timer_next  = '0;
            proximo     = one_hot ? ESPERA_SOLTA : ERRO;
          end else if (finalizar && (tamanho != 5'd0)) begin
            proximo = PRONTO;
          end else if (timer == TIMER_MAX) begin
            proximo = ERRO;
          end else begin
            timer_next = timer + 1'b1;
          end
        end
        ESPERA_SOLTA: begin
          if (botoes == 4'd0) proximo = GRAVA;
        end
        // The 16th write fills the memory and closes the recording by itself
        GRAVA: begin
          write_en     = 1'b1;
          tamanho_next = tamanho + 5'd1;
          timer_next   = '0;
          proximo      = (tamanho == 5'd15) ? PRONTO : ESPERA_JOGADA;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (write_en) mem[tamanho[3:0]] <= jogada_reg;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) data_out <= 4'd0;
    else        data_out <= mem[address];
  end

  assign ultimo    = (tamanho != 5'd0) && ({1'b0, address} == (tamanho - 5'd1));
  assign gravando  = (estado == ESPERA_JOGADA) || (estado == ESPERA_SOLTA) || (estado == GRAVA);
  assign pronto    = (estado == PRONTO);
  assign erro      = (estado == ERRO);
  assign db_estado = estado;

endmodule
